// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline stage register: valid/ready handshake, optional skid entry,
// flush-to-bubble, debug-unit freeze and a saturating bubble counter.
module id_ex_pipe_reg #(
  parameter int NB_REG  = 32,
  parameter int N_DATA  = 4,
  parameter int NB_CTRL = 18,
  parameter int SKID    = 1,
  parameter int NB_CNT  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_dunit_clk_en,
  input  logic                     i_flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [N_DATA*NB_REG-1:0] i_data,
  input  logic [NB_CTRL-1:0]       i_ctrl,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [N_DATA*NB_REG-1:0] o_data,
  output logic [NB_CTRL-1:0]       o_ctrl,
  output logic                     o_skid_full,
  output logic [NB_CNT-1:0]        o_bubble_cnt
);

  localparam int NB_DATA = N_DATA * NB_REG;

  logic               r_valid;
  logic [NB_DATA-1:0] r_data;
  logic [NB_CTRL-1:0] r_ctrl;
  logic               r_skid_valid;
  logic [NB_DATA-1:0] r_skid_data;
  logic [NB_CTRL-1:0] r_skid_ctrl;
  logic [NB_CNT-1:0]  r_cnt;

  logic w_en;
  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_occupied;

  assign w_en = i_dunit_clk_en;

  // With a skid entry, o_ready depends only on registered state, so no
  // combinational path runs from i_ready back to o_ready.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign w_ready = ~r_skid_valid & w_en;
    end else begin : g_single_ready
      assign w_ready = (~r_valid | i_ready) & w_en;
    end
  endgenerate

  assign w_push     = i_valid & w_ready;
  assign w_pop      = r_valid & i_ready & w_en;
  assign w_occupied = r_valid | r_skid_valid | w_push;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_ctrl       <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
      r_cnt        <= '0;
    end else if (w_en) begin
      if (i_flush) begin
        r_valid      <= 1'b0;
        r_data       <= '0;
        r_ctrl       <= '0;
        r_skid_valid <= 1'b0;
        r_skid_data  <= '0;
        r_skid_ctrl  <= '0;
        if (w_occupied && (r_cnt != '1)) begin
          r_cnt <= r_cnt + NB_CNT'(1);
        end
      end else if (w_pop && r_skid_valid) begin
        // The older skid entry moves up; o_ready is low, so no push can collide.
        r_valid      <= 1'b1;
        r_data       <= r_skid_data;
        r_ctrl       <= r_skid_ctrl;
        r_skid_valid <= 1'b0;
      end else if (w_push && (!r_valid || w_pop)) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
        r_ctrl  <= i_ctrl;
      end else if (w_push && (SKID != 0)) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= i_data;
        r_skid_ctrl  <= i_ctrl;
      end else if (w_pop) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end
    end
  end

  assign o_ready      = w_ready;
  assign o_valid      = r_valid;
  assign o_data       = r_data;
  assign o_ctrl       = r_ctrl;
  assign o_skid_full  = r_skid_valid;
  assign o_bubble_cnt = r_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: a default skid instance and a narrow
// single-entry instance with a 2-bit bubble counter.
module tb_id_ex_pipe_reg;

  logic clk;
  logic rstN;
  int   checks;
  int   errors;

  logic         aEn, aFlush, aValid, aReady;
  logic [127:0] aData;
  logic [17:0]  aCtrl;
  logic         aOReady, aOValid, aOSkid;
  logic [127:0] aOData;
  logic [17:0]  aOCtrl;
  logic [15:0]  aOCnt;

  logic         bEn, bFlush, bValid, bReady;
  logic [31:0]  bData;
  logic [17:0]  bCtrl;
  logic         bOReady, bOValid, bOSkid;
  logic [31:0]  bOData;
  logic [17:0]  bOCtrl;
  logic [1:0]   bOCnt;

  localparam logic [127:0] WORDS_A = {32'h1234_5678, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
  localparam logic [127:0] WORDS_B = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  localparam logic [127:0] WORDS_C = {32'h9999_9999, 32'h8888_8888, 32'h7777_7777, 32'h6666_6666};
  localparam logic [127:0] WORDS_D = {32'hDDDD_0004, 32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001};

  id_ex_pipe_reg dutA (
    .i_clk(clk), .i_reset(rstN), .i_dunit_clk_en(aEn), .i_flush(aFlush),
    .i_valid(aValid), .o_ready(aOReady), .i_data(aData), .i_ctrl(aCtrl),
    .o_valid(aOValid), .i_ready(aReady), .o_data(aOData), .o_ctrl(aOCtrl),
    .o_skid_full(aOSkid), .o_bubble_cnt(aOCnt)
  );

  id_ex_pipe_reg #(.NB_REG(16), .N_DATA(2), .NB_CTRL(18), .SKID(0), .NB_CNT(2)) dutB (
    .i_clk(clk), .i_reset(rstN), .i_dunit_clk_en(bEn), .i_flush(bFlush),
    .i_valid(bValid), .o_ready(bOReady), .i_data(bData), .i_ctrl(bCtrl),
    .o_valid(bOValid), .i_ready(bReady), .o_data(bOData), .o_ctrl(bOCtrl),
    .o_skid_full(bOSkid), .o_bubble_cnt(bOCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic en, input logic flush, input logic valid,
                               input logic ready, input logic [127:0] data, input logic [17:0] ctrl);
    aEn = en; aFlush = flush; aValid = valid; aReady = ready; aData = data; aCtrl = ctrl;
  endtask

  task automatic applyStimulusNarrow(input logic en, input logic flush, input logic valid,
                                     input logic ready, input logic [31:0] data, input logic [17:0] ctrl);
    bEn = en; bFlush = flush; bValid = valid; bReady = ready; bData = data; bCtrl = ctrl;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstN = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulusNarrow(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_valid", aOValid, 1'b0);
    checkOutput("rst_data", aOData, '0);
    checkOutput("rst_ctrl", aOCtrl, '0);
    checkOutput("rst_skid", aOSkid, 1'b0);
    checkOutput("rst_cnt", aOCnt, '0);
    rstN = 1'b1;
    #1;
    checkOutput("rst_ready", aOReady, 1'b1);

    // First entry passes straight to the outputs
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, WORDS_A, 18'h3FFFF);
    tick();
    checkOutput("push_valid", aOValid, 1'b1);
    checkOutput("push_data", aOData, WORDS_A);
    checkOutput("push_ctrl", aOCtrl, 18'h3FFFF);

    // Downstream stall: second entry lands in the skid buffer
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, WORDS_B, 18'h0F0F0);
    tick();
    checkOutput("stall_skid", aOSkid, 1'b1);
    checkOutput("stall_ready", aOReady, 1'b0);
    checkOutput("stall_data", aOData, WORDS_A);
    checkOutput("stall_ctrl", aOCtrl, 18'h3FFFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    tick();
    checkOutput("drain_data", aOData, WORDS_B);
    checkOutput("drain_ctrl", aOCtrl, 18'h0F0F0);
    checkOutput("drain_valid", aOValid, 1'b1);
    checkOutput("drain_skid", aOSkid, 1'b0);
    checkOutput("drain_ready", aOReady, 1'b1);

    // Debug freeze ignores valid, ready and flush
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, WORDS_C, 18'h00001);
    #1;
    checkOutput("frz_ready", aOReady, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("frz_valid", aOValid, 1'b1);
    checkOutput("frz_data", aOData, WORDS_B);
    checkOutput("frz_ctrl", aOCtrl, 18'h0F0F0);
    checkOutput("frz_cnt", aOCnt, 16'd0);
    checkOutput("frz_ready2", aOReady, 1'b0);

    // Flush beats a simultaneous push and pop
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, WORDS_C, 18'h00001);
    tick();
    checkOutput("flush_valid", aOValid, 1'b0);
    checkOutput("flush_ctrl", aOCtrl, '0);
    checkOutput("flush_data", aOData, '0);
    checkOutput("flush_cnt", aOCnt, 16'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, '0, '0);
    tick();
    checkOutput("flush_empty_cnt", aOCnt, 16'd1);

    // Pop without push leaves a bubble with zero control but held data
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, WORDS_D, 18'h2AAAA);
    tick();
    checkOutput("d_data", aOData, WORDS_D);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    tick();
    checkOutput("pop_valid", aOValid, 1'b0);
    checkOutput("pop_ctrl", aOCtrl, '0);
    checkOutput("pop_data", aOData, WORDS_D);

    // Fill main and skid, then reset asynchronously mid-cycle
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, WORDS_A, 18'h11111);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, WORDS_B, 18'h22222);
    tick();
    checkOutput("full_skid", aOSkid, 1'b1);
    checkOutput("full_ready", aOReady, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_valid", aOValid, 1'b0);
    checkOutput("arst_ctrl", aOCtrl, '0);
    checkOutput("arst_data", aOData, '0);
    checkOutput("arst_skid", aOSkid, 1'b0);
    checkOutput("arst_cnt", aOCnt, 16'd0);
    tick();
    rstN = 1'b1;
    #1;

    // Narrow single-entry instance
    applyStimulusNarrow(1'b1, 1'b0, 1'b1, 1'b1, 32'hBBBB_AAAA, 18'h3FFFF);
    tick();
    checkOutput("n_push_valid", bOValid, 1'b1);
    checkOutput("n_push_data", bOData, 32'hBBBB_AAAA);
    checkOutput("n_push_ctrl", bOCtrl, 18'h3FFFF);
    applyStimulusNarrow(1'b1, 1'b0, 1'b1, 1'b0, 32'h2222_1111, 18'h0F0F0);
    #1;
    checkOutput("n_stall_ready", bOReady, 1'b0);
    tick();
    checkOutput("n_stall_data", bOData, 32'hBBBB_AAAA);
    checkOutput("n_stall_skid", bOSkid, 1'b0);
    applyStimulusNarrow(1'b1, 1'b0, 1'b1, 1'b1, 32'h2222_1111, 18'h0F0F0);
    #1;
    checkOutput("n_pass_ready", bOReady, 1'b1);
    tick();
    checkOutput("n_pass_data", bOData, 32'h2222_1111);
    checkOutput("n_pass_ctrl", bOCtrl, 18'h0F0F0);

    // Every flush sees an incoming push, so the 2-bit counter saturates
    applyStimulusNarrow(1'b1, 1'b1, 1'b1, 1'b1, 32'h5555_5555, 18'h00003);
    tick();
    checkOutput("n_cnt1", bOCnt, 2'd1);
    tick();
    checkOutput("n_cnt2", bOCnt, 2'd2);
    tick();
    checkOutput("n_cnt3", bOCnt, 2'd3);
    tick();
    checkOutput("n_cnt4", bOCnt, 2'd3);
    tick();
    checkOutput("n_cnt5", bOCnt, 2'd3);
    checkOutput("n_flush_valid", bOValid, 1'b0);
    checkOutput("n_flush_ctrl", bOCtrl, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
